// File: rtl/seq_gen_pkg.sv
// Shared encodings for the sequence state generator: FSM states,
// count direction and wrap/one-shot mode constants.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_WRAP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/seq_state_gen_bin2gray.sv
// Purely combinational binary-to-Gray converter, WIDTH bits wide.
module bin2gray #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray[WIDTH-1] = bin[WIDTH-1];

   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
         assign gray[gi] = bin[gi+1] ^ bin[gi];
      end
   endgenerate

endmodule

// File: rtl/seq_state_gen.sv
// Modulo-(MAX+1) up/down sequencer with load, wrap/one-shot modes and a registered done pulse.
// Build option SEQ_STATE_GEN_GRAY_EN: dout1 is Gray of dout0, otherwise dout0 delayed one cycle.
module seq_state_gen
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int MAX   = 2**WIDTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] dout0,
   output logic [WIDTH-1:0] dout1,
   output logic             done,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] dout1_reg, dout1_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] step_val;
   logic             at_term;

   // Wrap explicitly at MAX/0 so codes above MAX can never be produced.
   always_comb begin
      if (dir == DIR_DOWN) begin
         step_val = (count_reg == '0) ? MAX_V : count_reg - ONE_V;
         at_term  = (step_val == '0);
      end else begin
         step_val = (count_reg == MAX_V) ? '0 : count_reg + ONE_V;
         at_term  = (step_val == MAX_V);
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      done_next  = 1'b0;
      if (load) begin
         count_next = (load_val > MAX_V) ? MAX_V : load_val;
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE, S_RUN: begin
               if (en) begin
                  count_next = step_val;
                  done_next  = at_term;
                  state_next = (at_term && mode == MODE_ONESHOT) ? S_HOLD : S_RUN;
               end
            end
            S_HOLD:  state_next = S_HOLD;
            default: state_next = S_IDLE;
         endcase
      end
   end

`ifdef SEQ_STATE_GEN_GRAY_EN
   logic [WIDTH-1:0] gray_next;

   bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
      .bin  (count_next),
      .gray (gray_next)
   );

   assign dout1_next = gray_next;
`else
   // Previous-state view; a load restarts the history at zero.
   assign dout1_next = load ? '0 : count_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         count_reg <= '0;
         dout1_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         dout1_reg <= dout1_next;
         done_reg  <= done_next;
      end
   end

   assign dout0 = count_reg;
   assign dout1 = dout1_reg;
   assign done  = done_reg;
   assign busy  = (state_reg == S_RUN);

endmodule

// File: tb/tb_seq_state_gen.sv
// Directed scoreboard bench for seq_state_gen: a 2-bit/MAX=3 instance and a 4-bit/MAX=9 instance.
module tb_seq_state_gen;

   typedef struct {
      logic [3:0] d0;
      logic [3:0] d1;
      logic       done;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a, en_a, dir_a, mode_a, load_a;
   logic [1:0] load_val_a, dout0_a, dout1_a;
   logic       done_a, busy_a;
   logic       rst_b, en_b, dir_b, mode_b, load_b;
   logic [3:0] load_val_b, dout0_b, dout1_b;
   logic       done_b, busy_b;

   exp_t       sb_q[$];
   logic [3:0] prev_a = 4'd0;
   logic [3:0] prev_b = 4'd0;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   seq_state_gen #(.WIDTH(2), .MAX(3)) u_dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .dir(dir_a), .mode(mode_a),
      .load(load_a), .load_val(load_val_a),
      .dout0(dout0_a), .dout1(dout1_a), .done(done_a), .busy(busy_a)
   );

   seq_state_gen #(.WIDTH(4), .MAX(9)) u_dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .dir(dir_b), .mode(mode_b),
      .load(load_b), .load_val(load_val_b),
      .dout0(dout0_b), .dout1(dout1_b), .done(done_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the selected instance (the other is parked in reset),
   // push the expected outputs, then pop and compare after the edge.
   task automatic run_step(input bit sel, input logic rs, input logic ld, input logic e,
                           input logic d, input logic m, input logic [3:0] lv,
                           input logic [3:0] e0, input logic edone, input logic ebusy,
                           input string tag);
      exp_t       x;
      exp_t       got;
      logic [3:0] e1;
      if (sel == 1'b0) begin
         rst_a = rs; load_a = ld; en_a = e; dir_a = d; mode_a = m; load_val_a = lv[1:0];
         rst_b = 1'b1; load_b = 1'b0; en_b = 1'b0;
      end else begin
         rst_b = rs; load_b = ld; en_b = e; dir_b = d; mode_b = m; load_val_b = lv;
         rst_a = 1'b1; load_a = 1'b0; en_a = 1'b0;
      end
`ifdef SEQ_STATE_GEN_GRAY_EN
      e1 = (e0 >> 1) ^ e0;
`else
      e1 = (rs || ld) ? 4'd0 : (sel ? prev_b : prev_a);
`endif
      if (sel) prev_b = e0; else prev_a = e0;
      x.d0 = e0; x.d1 = e1; x.done = edone; x.busy = ebusy;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      if (sel == 1'b0) begin
         got.d0 = {2'b00, dout0_a}; got.d1 = {2'b00, dout1_a};
         got.done = done_a; got.busy = busy_a;
      end else begin
         got.d0 = dout0_b; got.d1 = dout1_b; got.done = done_b; got.busy = busy_b;
      end
      $display("step %s: dout0=%0d dout1=%0d done=%0b busy=%0b", tag, got.d0, got.d1, got.done, got.busy);
      check({tag, ".dout0"}, got.d0, x.d0);
      check({tag, ".dout1"}, got.d1, x.d1);
      check({tag, ".done"}, {3'b000, got.done}, {3'b000, x.done});
      check({tag, ".busy"}, {3'b000, got.busy}, {3'b000, x.busy});
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b0; dir_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; load_val_a = '0;
      rst_b = 1'b1; en_b = 1'b0; dir_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; load_val_b = '0;
      repeat (2) @(posedge clk);
      #1;

      // Instance A: WIDTH=2, MAX=3, up, wrap
      run_step(0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "a_reset");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 1, "a_up1");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd2, 0, 1, "a_up2");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd3, 1, 1, "a_up3");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, "a_wrap0");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 1, "a_up1b");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd2, 0, 1, "a_up2b");
      run_step(0, 0, 0, 1, 0, 0, 4'd0, 4'd3, 1, 1, "a_up3b");

      // Instance B: WIDTH=4, MAX=9, down wrap from load 2
      run_step(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "b_reset");
      run_step(1, 0, 1, 0, 1, 0, 4'd2, 4'd2, 0, 0, "b_load2");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 1, "b_dn1");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 1, "b_dn0");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 1, "b_dnwrap9");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd8, 0, 1, "b_dn8");

      // Load clamp beats en on the same edge
      run_step(1, 0, 1, 1, 0, 0, 4'd15, 4'd9, 0, 0, "b_clamp");

      // One-shot up from 0 to 9, then HOLD ignores en
      run_step(1, 0, 1, 0, 0, 1, 4'd0, 4'd0, 0, 0, "b_load0");
      for (int i = 1; i <= 8; i++)
         run_step(1, 0, 0, 1, 0, 1, 4'd0, 4'(i), 0, 1, $sformatf("b_os%0d", i));
      run_step(1, 0, 0, 1, 0, 1, 4'd0, 4'd9, 1, 0, "b_os_term");
      run_step(1, 0, 0, 1, 0, 1, 4'd0, 4'd9, 0, 0, "b_hold1");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 0, "b_hold2");
      run_step(1, 0, 1, 0, 0, 1, 4'd4, 4'd4, 0, 0, "b_load4");
      run_step(1, 0, 0, 0, 0, 1, 4'd0, 4'd4, 0, 0, "b_idle4");

      // Reset mid-run overrides load and en
      run_step(1, 0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 1, "b_run5");
      run_step(1, 1, 1, 1, 0, 0, 4'd7, 4'd0, 0, 0, "b_rst_mid");

      // en gaps and dir flip at 3, then down through the terminal
      run_step(1, 0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 1, "b_g1");
      run_step(1, 0, 0, 1, 0, 0, 4'd0, 4'd2, 0, 1, "b_g2");
      run_step(1, 0, 0, 1, 0, 0, 4'd0, 4'd3, 0, 1, "b_g3");
      run_step(1, 0, 0, 0, 1, 0, 4'd0, 4'd3, 0, 1, "b_gap3");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd2, 0, 1, "b_flip2");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 1, "b_flip1");
      run_step(1, 0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 1, "b_flip0");

      // Loading the terminal value gives no done; the next up step wraps to 0
      run_step(1, 0, 1, 0, 0, 0, 4'd9, 4'd9, 0, 0, "b_load9");
      run_step(1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, "b_wrap_from9");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
